// File: rtl/pm_pkg.sv
// Shared types and constants for the postmortem capture sequencer:
// capture/issuer state encodings, writer word size and header formatting.
package pm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_POST   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FROZEN = 3'd4
  } pm_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_e;

  localparam int unsigned WORD_BYTES = 8;
  localparam logic [7:0]  HDR_MAGIC  = 8'hA5;

  // Byte address of a ring entry; each entry is one 64-bit writer word.
  function automatic logic [39:0] ring_addr(input logic [39:0] base,
                                            input logic [31:0] idx);
    return base + 40'(idx) * 40'(WORD_BYTES);
  endfunction

  // Header word: magic, wrap flag, overflow count, zero-extended trigger index.
  function automatic logic [63:0] hdr_word(input logic        wrapped,
                                           input logic [15:0] ovf,
                                           input logic [31:0] trig);
    return {HDR_MAGIC, 7'b0, wrapped, ovf, trig};
  endfunction

endpackage

// File: rtl/pm_sample_fifo.sv
// Synchronous show-ahead FIFO holding {ring index, sample} pairs between
// the sample stream and the single-beat writer issuer.
module pm_sample_fifo #(
  parameter int unsigned WIDTH = 76,
  parameter int unsigned LOG2  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2:0]    wr_ptr;
  logic [LOG2:0]    rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                   (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign rd_data = mem[rd_ptr[LOG2-1:0]];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (LOG2 + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (LOG2 + 1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers define validity,
  // and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/pm_capture_ctrl.sv
// Postmortem capture sequencer: buffers samples, issues one writer transaction
// per sample into a DDR ring, freezes after a trigger. Optional macro PM_HDR_EN.
module pm_capture_ctrl
  import pm_pkg::*;
#(
  parameter logic [39:0] BASE_ADDR  = 40'h0_1000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned POST_CNT   = 1024,
  parameter int unsigned FIFO_LOG2  = 4,
  parameter logic [39:0] HDR_ADDR   = 40'h0_0FFF_FFF8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_arm,
  input  logic                  i_trig,
  input  logic                  i_smp_valid,
  input  logic [63:0]           i_smp_data,
  output logic                  o_wr_start,
  output logic [39:0]           o_wr_addr,
  output logic [63:0]           o_wr_data,
  input  logic                  i_wr_done,
  output logic [2:0]            o_state,
  output logic                  o_frozen,
  output logic [DEPTH_LOG2-1:0] o_trig_idx,
  output logic                  o_wrapped,
  output logic [15:0]           o_ovf_cnt
);

  localparam int unsigned           FW        = DEPTH_LOG2 + 64;
  localparam logic [DEPTH_LOG2-1:0] IDX_MAX   = '1;
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_CNT - 1);

  pm_state_e             state, state_nxt;
  wr_state_e             w_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] post_cnt;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_rd;
  logic          capture, drop, arm_now, trig_now, counting, post_hit;
  logic          issue_hdr, drain_done;

`ifdef PM_HDR_EN
  logic hdr_sent;
`else
  logic [39:0] unused_hdr_addr;
  assign unused_hdr_addr = HDR_ADDR;
`endif

  pm_sample_fifo #(
    .WIDTH (FW),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (fifo_push),
    .push_data ({wr_idx, i_smp_data}),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issuer: one outstanding writer transaction; the header goes out only once
  // the ring data has fully drained.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value held (no latch is inferred).
    w_state_nxt = w_state;
    fifo_pop    = 1'b0;
    issue_hdr   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          w_state_nxt = W_BUSY;
        end
`ifdef PM_HDR_EN
        else if (state == ST_DRAIN && !hdr_sent) begin
          issue_hdr   = 1'b1;
          w_state_nxt = W_BUSY;
        end
`endif
      end
      W_BUSY: if (i_wr_done) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    capture   = (state == ST_ARMED || state == ST_POST) && i_smp_valid;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    fifo_push = capture && (!fifo_full || fifo_pop);
    drop      = capture && fifo_full && !fifo_pop;
    arm_now   = (state == ST_IDLE || state == ST_FROZEN) && i_arm;
    trig_now  = (state == ST_ARMED) && i_trig;
    counting  = trig_now || (state == ST_POST);
    post_hit  = counting && fifo_push && (post_cnt == POST_LAST);
`ifdef PM_HDR_EN
    drain_done = hdr_sent && (w_state == W_IDLE);
`else
    drain_done = fifo_empty && (w_state == W_IDLE);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arm_now)    state_nxt = ST_ARMED;
      ST_ARMED:  if (trig_now)   state_nxt = post_hit ? ST_DRAIN : ST_POST;
      ST_POST:   if (post_hit)   state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_done) state_nxt = ST_FROZEN;
      ST_FROZEN: if (arm_now)    state_nxt = ST_ARMED;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ST_IDLE;
      w_state    <= W_IDLE;
      o_wr_start <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      wr_idx     <= '0;
      post_cnt   <= '0;
      o_trig_idx <= '0;
      o_wrapped  <= 1'b0;
      o_ovf_cnt  <= '0;
`ifdef PM_HDR_EN
      hdr_sent   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      w_state    <= w_state_nxt;
      o_wr_start <= fifo_pop || issue_hdr;
      if (fifo_pop) begin
        o_wr_addr <= ring_addr(BASE_ADDR, 32'(fifo_rd[FW-1:64]));
        o_wr_data <= fifo_rd[63:0];
      end
`ifdef PM_HDR_EN
      else if (issue_hdr) begin
        o_wr_addr <= HDR_ADDR;
        o_wr_data <= hdr_word(o_wrapped, o_ovf_cnt, 32'(o_trig_idx));
      end
`endif
      if (arm_now) begin
        wr_idx     <= '0;
        post_cnt   <= '0;
        o_trig_idx <= '0;
        o_wrapped  <= 1'b0;
        o_ovf_cnt  <= '0;
`ifdef PM_HDR_EN
        hdr_sent   <= 1'b0;
`endif
      end else begin
        if (trig_now) o_trig_idx <= wr_idx;
        if (fifo_push) begin
          wr_idx <= wr_idx + DEPTH_LOG2'(1);
          if (wr_idx == IDX_MAX) o_wrapped <= 1'b1;
          if (counting) post_cnt <= post_cnt + DEPTH_LOG2'(1);
        end
        if (drop && o_ovf_cnt != 16'hFFFF) o_ovf_cnt <= o_ovf_cnt + 16'd1;
`ifdef PM_HDR_EN
        if (issue_hdr) hdr_sent <= 1'b1;
`endif
      end
    end
  end

  assign o_state  = state;
  assign o_frozen = (state == ST_FROZEN);

endmodule

// File: tb/tb_pm_capture_ctrl.sv
// Self-checking bench for pm_capture_ctrl (small ring: DEPTH_LOG2=4, POST_CNT=5);
// honours PM_HDR_EN when defined for the build.
module tb_pm_capture_ctrl;

  localparam logic [39:0] BASE = 40'h0_1000_0000;
  localparam logic [39:0] HDR  = 40'h0_0FFF_FFF8;
  localparam int D    = 4;
  localparam int RING = 16;
  localparam int PC   = 5;
  localparam int F    = 4;
  localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DRAIN = 3, S_FROZEN = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_arm, i_trig, i_smp_valid, i_wr_done;
  logic [63:0]   i_smp_data;
  logic          o_wr_start, o_frozen, o_wrapped;
  logic [39:0]   o_wr_addr;
  logic [63:0]   o_wr_data;
  logic [2:0]    o_state;
  logic [D-1:0]  o_trig_idx;
  logic [15:0]   o_ovf_cnt;

  pm_capture_ctrl #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (D),
    .POST_CNT   (PC),
    .FIFO_LOG2  (F),
    .HDR_ADDR   (HDR)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_arm       (i_arm),
    .i_trig      (i_trig),
    .i_smp_valid (i_smp_valid),
    .i_smp_data  (i_smp_data),
    .o_wr_start  (o_wr_start),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .i_wr_done   (i_wr_done),
    .o_state     (o_state),
    .o_frozen    (o_frozen),
    .o_trig_idx  (o_trig_idx),
    .o_wrapped   (o_wrapped),
    .o_ovf_cnt   (o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected writes in order plus capture bookkeeping.
  logic [103:0] exp_q[$];
  int           m_st = S_IDLE, m_idx = 0, m_trig = 0, m_post = 0;
  bit           m_wrapped = 1'b0;
  logic [15:0]  m_ovf = '0;
  int           n_acc = 0, n_done = 0, n_starts = 0;
  int           done_lat = 4;
  bit           busy = 1'b0;

  // Writer responder and scoreboard.
  logic [103:0] e;
  logic [39:0]  ha;
  logic [63:0]  hd;
  initial begin
    i_wr_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst && o_wr_start) begin
        n_starts++;
        busy = 1'b1;
        ha = o_wr_addr;
        hd = o_wr_data;
        if (exp_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", o_wr_addr, e[103:64]);
          check("wr_data", o_wr_data, e[63:0]);
        end
        for (int k = 1; k < done_lat; k++) begin
          @(negedge i_clk);
          if (!i_rst) break;
          check("hold_addr", o_wr_addr, ha);
          check("hold_data", o_wr_data, hd);
          check("start_while_busy", o_wr_start, 0);
        end
        if (i_rst) begin
          i_wr_done = 1'b1;
          @(negedge i_clk);
          i_wr_done = 1'b0;
          n_done++;
          if (i_rst) check("start_in_done_cycle", o_wr_start, 0);
        end
        busy = 1'b0;
      end
    end
  end

  task automatic model_clear();
    m_idx = 0; m_trig = 0; m_post = 0; m_wrapped = 1'b0; m_ovf = '0;
  endtask

  // Drive one clock cycle of inputs, advance the model by that cycle's rules,
  // then compare the architectural outputs after the edge.
  task automatic cycle(input bit arm, input bit trig, input bit valid, input logic [63:0] data);
    i_arm = arm; i_trig = trig; i_smp_valid = valid; i_smp_data = data;
    if ((m_st == S_IDLE || m_st == S_FROZEN) && arm) begin
      m_st = S_ARMED;
      model_clear();
    end else if (m_st == S_ARMED || m_st == S_POST) begin
      if (m_st == S_ARMED && trig) begin
        m_trig = m_idx;
        m_st = S_POST;
      end
      if (valid) begin
        // Room for 2**F queued samples plus the one the writer is holding.
        if (n_acc - n_done < (1 << F) + 1) begin
          exp_q.push_back({BASE + 40'(m_idx) * 40'd8, data});
          n_acc++;
          if (m_idx == RING - 1) m_wrapped = 1'b1;
          m_idx = (m_idx + 1) % RING;
          if (m_st == S_POST) begin
            m_post++;
            if (m_post == PC) begin
              m_st = S_DRAIN;
`ifdef PM_HDR_EN
              exp_q.push_back({HDR, 8'hA5, 7'b0, m_wrapped, m_ovf, 28'h0, 4'(m_trig)});
`endif
            end
          end
        end else if (m_ovf != 16'hFFFF) m_ovf++;
      end
    end
    @(negedge i_clk);
    i_arm = 1'b0; i_trig = 1'b0; i_smp_valid = 1'b0;
    if (m_st != S_DRAIN) check("state", o_state, m_st);
    check("wrapped", o_wrapped, m_wrapped);
    check("ovf_cnt", o_ovf_cnt, m_ovf);
    check("trig_idx", o_trig_idx, m_trig);
  endtask

  task automatic wait_frozen(input int budget);
    int n = 0;
    while (!o_frozen && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check("frozen_reached", o_frozen, 1);
    check("idle_writer_at_freeze", busy, 0);
    check("all_writes_seen", exp_q.size(), 0);
    check("frozen_state", o_state, S_FROZEN);
    check("frozen_trig_idx", o_trig_idx, m_trig);
    check("frozen_wrapped", o_wrapped, m_wrapped);
    check("frozen_ovf", o_ovf_cnt, m_ovf);
    m_st = S_FROZEN;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  int s0, guard;

  initial begin
    i_rst = 1'b0; i_arm = 1'b0; i_trig = 1'b0; i_smp_valid = 1'b0; i_smp_data = '0;
    repeat (3) @(negedge i_clk);
    check("rst_state", o_state, 0);
    check("rst_frozen", o_frozen, 0);
    check("rst_start", o_wr_start, 0);
    check("rst_addr", o_wr_addr, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_trig_idx", o_trig_idx, 0);
    check("rst_wrapped", o_wrapped, 0);
    check("rst_ovf", o_ovf_cnt, 0);
    i_rst = 1'b1;

    // Three samples, writer done 4 cycles after each start.
    done_lat = 4;
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, rnd64());
    repeat (25) cycle(0, 0, 0, '0);
    check("three_starts", n_starts, 3);

    // Fill to index 20 (wraps), then trigger with a sample: trig_idx = 4.
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, rnd64());
    repeat (100) cycle(0, 0, 0, '0);
    cycle(0, 1, 1, rnd64());
    check("trig_idx_is_4", o_trig_idx, 4);
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, 0, 1, rnd64());   // arm during POST must be ignored
      cycle(0, 0, 0, '0);
    end
    wait_frozen(400);
    check("wrapped_after_20", o_wrapped, 1);
    cycle(0, 1, 0, '0);               // trigger while frozen is ignored
    cycle(1, 0, 0, '0);               // re-arm clears counters
    check("rearm_ovf", o_ovf_cnt, 0);
    check("rearm_trig", o_trig_idx, 0);

    // Stalled writer: 20 back-to-back samples, 17 held, 3 dropped.
    done_lat = 50;
    s0 = n_starts;
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, rnd64());
    guard = 0;
    while (n_done != n_acc && guard < 3000) begin
      cycle(0, 0, 0, '0);
      guard++;
    end
    check("stall_drained", n_done == n_acc, 1);
    check("stall_ovf", o_ovf_cnt, 3);
    check("stall_starts", n_starts - s0, 17);
    done_lat = 3;
    cycle(0, 1, 0, '0);
    for (int i = 0; i < PC; i++) begin
      cycle(0, 0, 1, rnd64());
      cycle(0, 0, 0, '0);
    end
    wait_frozen(400);

    // Randomised rounds.
    for (int r = 0; r < 4; r++) begin
      done_lat = $urandom_range(2, 4);
      cycle(1, 0, 0, '0);
      repeat ($urandom_range(10, 120)) cycle(0, 0, $urandom_range(0, 7) == 0, rnd64());
      cycle(0, 1, $urandom_range(0, 1) == 1, rnd64());
      guard = 0;
      while (m_st == S_POST && guard < 2000) begin
        cycle(0, 0, $urandom_range(0, 7) == 0, rnd64());
        guard++;
      end
      wait_frozen(500);
    end

    // Reset while a write is in flight during POST.
    done_lat = 20;
    cycle(1, 0, 0, '0);
    cycle(0, 1, 1, rnd64());
    cycle(0, 0, 1, rnd64());
    guard = 0;
    while (!busy && guard < 20) begin
      cycle(0, 0, 0, '0);
      guard++;
    end
    check("busy_before_reset", busy, 1);
    #2 i_rst = 1'b0;
    #1;
    check("mid_rst_state", o_state, 0);
    check("mid_rst_start", o_wr_start, 0);
    check("mid_rst_addr", o_wr_addr, 0);
    check("mid_rst_data", o_wr_data, 0);
    check("mid_rst_trig", o_trig_idx, 0);
    check("mid_rst_wrapped", o_wrapped, 0);
    repeat (3) @(negedge i_clk);
    exp_q.delete();
    n_acc = 0; n_done = 0;
    m_st = S_IDLE;
    model_clear();
    i_rst = 1'b1;
    s0 = n_starts;
    repeat (20) cycle(0, 1, 1, rnd64());
    check("no_start_after_reset", n_starts - s0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pm_capture_ctrl.md
Name: pm_capture_ctrl

Overview:
Sequencer for the single-beat AXI4 postmortem DDR writer. Accepts a continuous 64-bit sample stream, buffers it in a small FIFO and schedules one writer transaction per sample into a circular DDR region. On a fault trigger it captures POST_CNT further samples, drains, then freezes the region for software readout. Sits between the MPS sample/fault logic and the writer's i_start/o_done/i_ddr_addr/i_ddr_data interface.

Parameters:
BASE_ADDR, 40'h0_1000_0000, byte address of ring entry 0 (8-byte aligned)
DEPTH_LOG2, 12, ring holds 2**DEPTH_LOG2 64-bit entries
POST_CNT, 1024, samples captured after trigger, 1..2**DEPTH_LOG2-1
FIFO_LOG2, 4, sample FIFO depth 2**FIFO_LOG2
HDR_ADDR, 40'h0_0FFF_FFF8, header word address (PM_HDR_EN only)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-low reset
i_arm  in  1  one-cycle pulse; (re)arms capture
i_trig  in  1  fault trigger, level; acted on in ARMED only
i_smp_valid  in  1  sample strobe
i_smp_data  in  64  sample word
o_wr_start  out  1  one-cycle start pulse to writer
o_wr_addr  out  40  DDR byte address to writer
o_wr_data  out  64  DDR data to writer
i_wr_done  in  1  writer completion pulse
o_state  out  3  IDLE=0 ARMED=1 POST=2 DRAIN=3 FROZEN=4
o_frozen  out  1  high in FROZEN
o_trig_idx  out  DEPTH_LOG2  ring index of first post-trigger sample
o_wrapped  out  1  ring index wrapped at least once since arm
o_ovf_cnt  out  16  dropped samples, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, indices 0; writer shares the same reset, in-flight AXI transfer abandoned.
- Main FSM: IDLE -i_arm-> ARMED; ARMED -i_trig-> POST; POST -post count reaches POST_CNT-> DRAIN; DRAIN -FIFO empty and issuer idle-> FROZEN; FROZEN -i_arm-> ARMED. i_arm ignored in ARMED/POST/DRAIN. i_trig ignored outside ARMED.
- Arm: clears write index, o_wrapped, o_ovf_cnt, o_trig_idx, post count; FIFO must already be empty (guaranteed by DRAIN).
- Enqueue: in ARMED/POST, i_smp_valid & FIFO not full -> push {index, data}; index increments mod 2**DEPTH_LOG2; index 2**DEPTH_LOG2-1 -> 0 sets o_wrapped. i_smp_valid with FIFO full -> drop, o_ovf_cnt+1 (saturate 16'hFFFF), index not advanced. Samples in IDLE/DRAIN/FROZEN ignored, not counted.
- Trigger cycle: o_trig_idx latches current write index; a sample enqueued that same cycle is the first post-trigger sample and counts toward POST_CNT. Post count counts only enqueued samples; transition to DRAIN the cycle after the POST_CNT-th enqueue; no enqueue from that cycle on.
- Issuer (sub-FSM W_IDLE/W_BUSY): in W_IDLE with FIFO non-empty -> pop, register o_wr_addr = BASE_ADDR + index*8, o_wr_data, pulse o_wr_start one cycle, go W_BUSY. W_BUSY -i_wr_done-> W_IDLE. Addr/data held stable from start until done. Exactly one start per done; next start no earlier than the cycle after done. Enqueue-to-start latency 1 cycle when issuer idle and FIFO was empty.
- Simultaneous push and pop on full FIFO: pop frees the slot, push accepted.

Optional Feature:
PM_HDR_EN: when defined, on DRAIN completion issuer performs one extra write to HDR_ADDR with data {8'hA5, 7'b0, o_wrapped, o_ovf_cnt, (32-DEPTH_LOG2)'b0, o_trig_idx}; FROZEN entered after its i_wr_done. Undefined: no header, FROZEN directly after drain.

Decomposition:
- Package pm_pkg: state encodings, writer word size constant (8 bytes), header magic 8'hA5.
- Sub-module pm_sample_fifo: synchronous FIFO, FIFO_LOG2 depth, width DEPTH_LOG2+64, full/empty flags, show-ahead read.

Test Plan:
- Arm, 3 samples, writer done 4 cycles after each start -> starts at addr BASE, BASE+8, BASE+16, data in order, o_wrapped=0.
- DEPTH_LOG2=4, POST_CNT=5: 20 samples then trigger with sample on same cycle -> o_trig_idx=4, 5 post samples written to indices 4..8, o_wrapped=1, FROZEN after last done.
- Writer done delayed 50 cycles, 20 back-to-back samples, FIFO_LOG2=4 -> 16 queued + 1 in flight, o_ovf_cnt=3, no start before prior done.
- i_arm during POST and i_trig during FROZEN -> no state change; i_arm in FROZEN -> ARMED, counters cleared.
- Reset asserted in W_BUSY mid-POST -> all outputs 0 immediately, IDLE, no further starts until re-armed.
- PM_HDR_EN, scenario 2 -> final write to HDR_ADDR data 64'hA501_0000_0000_0004 (ovf 0); FROZEN only after its done.
